uart_rx_sequencer: RTL and testbench

- Receive-side frame sequencer for the UART.
- Consumes the 16x oversampling strobe `sample_enable` produced by the Rx baud controller and the raw serial line `rx_in`.
- Detects start bits, samples each bit at its centre, assembles LSB-first data, checks the stop bit and optional parity, and presents the byte to the host through a valid/ack handshake with error flags.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx_sequencer.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receive sequencer: line inputs, acknowledge and frame outputs.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_enable;
  logic                 rx_in;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 ferror;
  logic                 perror;
  logic                 overrun;
  logic                 busy;

  modport master (
    output sample_enable, rx_in, rx_ack,
    input  rx_data, rx_valid, ferror, perror, overrun, busy
  );

  modport slave (
    input  sample_enable, rx_in, rx_ack,
    output rx_data, rx_valid, ferror, perror, overrun, busy
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive frame sequencer: start detect, mid-bit sampling, stop/parity check, valid/ack handshake.
// Define RX_PARITY_EN to compile in one even-parity bit between the data bits and the stop bit.
module uart_rx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  // START counts from 0 at the first low tick, so the bit centre lands on count OVERSAMPLE/2-2.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;
`endif

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 ferror_q;
  logic                 overrun_q;
  logic                 busy_q;
  logic                 tick_last;
`ifdef RX_PARITY_EN
  logic                 parity_q;
  logic                 perror_q;
`endif

  assign rx_s      = sync_q[1];
  assign tick_last = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to the idle line level so release never looks like a start bit.
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferror_q   <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RX_PARITY_EN
      parity_q   <= 1'b0;
      perror_q   <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], bus.rx_in};

      // NOTE: a completion further down reassigns rx_valid_q/overrun_q; with non-blocking
      // assignments the last one in the block wins, so a same-cycle ack yields the new frame.
      if (bus.rx_ack && rx_valid_q) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      if (bus.sample_enable) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
              busy_q     <= 1'b1;
            end
          end

          S_START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              if (rx_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          S_DATA: begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_last) begin
              shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end

`ifdef RX_PARITY_EN
          S_PARITY: begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_last) begin
              parity_q <= rx_s;
              state_q  <= S_STOP;
            end
          end
`endif

          S_STOP: begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_last) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              ferror_q   <= ~rx_s;
              overrun_q  <= rx_valid_q & ~bus.rx_ack;
`ifdef RX_PARITY_EN
              perror_q   <= (^shift_q) ^ parity_q;
`endif
              // A low stop bit parks in BREAK so a held-low line cannot start a new frame.
              state_q    <= rx_s ? S_IDLE : S_BREAK;
              busy_q     <= ~rx_s;
            end
          end

          S_BREAK: begin
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.ferror   = ferror_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;
`ifdef RX_PARITY_EN
  assign bus.perror   = perror_q;
`else
  assign bus.perror   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: directed scenarios plus randomized frames,
// compared every cycle against a tick-arithmetic model of the receive protocol.
`timescale 1ns/1ps
module tb_uart_rx_sequencer;
  localparam int DATA_BITS = 8;
  localparam int OVS       = 16;
  localparam int MID       = OVS / 2 - 1;
`ifdef RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_sequencer #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // Tick generator: one strobe every 4 clks unless frozen.
  int freeze_left = 0;
  initial begin
    int phase;
    phase = 0;
    bus.sample_enable = 1'b0;
    forever begin
      @(negedge clk);
      if (freeze_left > 0) begin
        freeze_left--;
        bus.sample_enable = 1'b0;
      end else begin
        phase = (phase + 1) % 4;
        bus.sample_enable = (phase == 0);
      end
    end
  end

  // Host acknowledge: explicit one-cycle pulses on request, plus random pulses when enabled.
  bit ack_req  = 1'b0;
  bit auto_ack = 1'b0;
  int ack_div  = 8;
  initial begin
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.rx_ack = ack_req || (auto_ack && ($urandom_range(0, ack_div) == 0));
      ack_req = 1'b0;
    end
  end

  // Reference model: counts ticks since the first low sample and decides by arithmetic
  // which frame position each tick falls on.
  logic [DATA_BITS-1:0] exp_data  = '0;
  bit                   exp_valid = 1'b0;
  bit                   exp_ferr  = 1'b0;
  bit                   exp_perr  = 1'b0;
  bit                   exp_ovr   = 1'b0;
  bit                   exp_busy  = 1'b0;
  initial begin
    int t, k;
    bit brk, h1, h2, rs, ack, done, par;
    logic [DATA_BITS-1:0] acc;
    t = -1; brk = 0; h1 = 1; h2 = 1; par = 0; acc = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        t = -1; brk = 0; h1 = 1; h2 = 1; par = 0; acc = '0;
        exp_data = '0; exp_valid = 0; exp_ferr = 0; exp_perr = 0; exp_ovr = 0; exp_busy = 0;
      end else begin
        rs = h2; h2 = h1; h1 = bus.rx_in;
        ack = bus.rx_ack;
        done = 0;
        if (bus.sample_enable) begin
          if (brk) begin
            if (rs) brk = 0;
          end else if (t < 0) begin
            if (!rs) begin t = 0; acc = '0; end
          end else begin
            t++;
            if (t == MID) begin
              if (rs) t = -1;
            end else if (t > MID && ((t - MID) % OVS) == 0) begin
              k = (t - MID) / OVS - 1;
              if (k < DATA_BITS) acc[k] = rs;
              else if (k < DATA_BITS + PAR_BITS) par = rs;
              else begin
                done = 1;
                t    = -1;
                brk  = !rs;
              end
            end
          end
        end
        if (done) begin
          if (exp_valid && !ack) exp_ovr = 1;
          else if (exp_valid && ack) exp_ovr = 0;
          exp_valid = 1;
          exp_data  = acc;
          exp_ferr  = !rs;
          exp_perr  = (PAR_BITS != 0) && ((^acc) ^ par);
        end else if (ack && exp_valid) begin
          exp_valid = 0;
          exp_ovr   = 0;
        end
        exp_busy = (t >= 0) || brk;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit cmp_on = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("cmp_rx_valid", bus.rx_valid, exp_valid);
        check("cmp_rx_data",  bus.rx_data,  exp_data);
        check("cmp_ferror",   bus.ferror,   exp_ferr);
        check("cmp_perror",   bus.perror,   exp_perr);
        check("cmp_overrun",  bus.overrun,  exp_ovr);
        check("cmp_busy",     bus.busy,     exp_busy);
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c, guard;
    c = 0; guard = 0;
    while (c < n) begin
      @(posedge clk);
      if (bus.sample_enable) c++;
      guard++;
      if (guard > 20000) begin
        $display("FAIL tick_wait: got %0d ticks, expected %0d", c, n);
        $fatal(1, "tick budget expired");
      end
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    bus.rx_in = b;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop, input bit par,
                            input int freeze_bit, input int freeze_len);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == freeze_bit) freeze_left = freeze_len;
      send_bit(d[i]);
    end
    if (PAR_BITS != 0) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic pulse_ack();
    ack_req = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [DATA_BITS-1:0] d;
    bit stop, par;
    int fb, fl;

    bus.rx_in = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data",  bus.rx_data,  0);
    check("reset_busy",     bus.busy,     0);
    check("reset_overrun",  bus.overrun,  0);
    rst = 1'b0;
    cmp_on = 1'b1;
    idle(20);

    // Basic frame
    d = 8'hA5;
    send_frame(d, 1'b1, even_par(d), -1, 0);
    idle(16);
    check("basic_data",   bus.rx_data,  8'hA5);
    check("basic_valid",  bus.rx_valid, 1);
    check("basic_ferror", bus.ferror,   0);
    check("basic_perror", bus.perror,   0);
    check("basic_busy",   bus.busy,     0);
    check("model_pin_basic_data", exp_data, 8'hA5);
    pulse_ack();
    check("basic_ack_valid", bus.rx_valid, 0);

    // Glitch shorter than half a bit
    bus.rx_in = 1'b0;
    repeat (16) @(negedge clk);
    bus.rx_in = 1'b1;
    check("glitch_busy_mid", bus.busy, 1);
    wait_ticks(16);
    check("glitch_busy_after",  bus.busy,     0);
    check("glitch_valid_after", bus.rx_valid, 0);

    // Framing error followed by a held-low line
    d = 8'h3C;
    send_frame(d, 1'b0, even_par(d), -1, 0);
    wait_ticks(3 * OVS);
    check("break_busy",   bus.busy,    1);
    check("break_data",   bus.rx_data, 8'h3C);
    check("break_ferror", bus.ferror,  1);
    check("model_pin_break_ferr", exp_ferr, 1);
    idle(3 * OVS);
    check("break_busy_released", bus.busy,     0);
    check("break_no_spurious",   bus.rx_data,  8'h3C);
    check("break_valid_held",    bus.rx_valid, 1);
    pulse_ack();

    // Overrun
    d = 8'h11;
    send_frame(d, 1'b1, even_par(d), -1, 0);
    idle(16);
    d = 8'h22;
    send_frame(d, 1'b1, even_par(d), -1, 0);
    idle(16);
    check("ovr_data",    bus.rx_data,  8'h22);
    check("ovr_overrun", bus.overrun,  1);
    check("ovr_valid",   bus.rx_valid, 1);
    check("model_pin_ovr", exp_ovr, 1);
    pulse_ack();
    check("ovr_ack_valid",   bus.rx_valid, 0);
    check("ovr_ack_overrun", bus.overrun,  0);

    // Parity
    d = 8'h07;
`ifdef RX_PARITY_EN
    send_frame(d, 1'b1, 1'b0, -1, 0);
    idle(16);
    check("parity_bad_perror", bus.perror, 1);
    pulse_ack();
    send_frame(d, 1'b1, 1'b1, -1, 0);
    idle(16);
    check("parity_good_perror", bus.perror, 0);
`else
    send_frame(d, 1'b1, 1'b0, -1, 0);
    idle(16);
    check("noparity_perror", bus.perror,  0);
    check("noparity_data",   bus.rx_data, 8'h07);
`endif

    // Reset during data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.rx_in = 1'b1;
    wait_ticks(8);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", bus.rx_valid, 0);
    check("midrst_data",  bus.rx_data,  0);
    check("midrst_busy",  bus.busy,     0);
    check("midrst_ferr",  bus.ferror,   0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(32);
    d = 8'h5A;
    send_frame(d, 1'b1, even_par(d), -1, 0);
    idle(16);
    check("post_rst_data",  bus.rx_data,  8'h5A);
    check("post_rst_valid", bus.rx_valid, 1);
    check("post_rst_ferr",  bus.ferror,   0);
    pulse_ack();

    // Randomized traffic: random data, stop/parity errors, breaks, freezes, glitches, acks
    auto_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d    = DATA_BITS'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = even_par(d) ^ ($urandom_range(0, 4) == 0);
      fb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_BITS - 1)) : -1;
      fl   = $urandom_range(1, 200);
      case ($urandom_range(0, 2))
        0:       ack_div = 2;
        1:       ack_div = 200;
        default: ack_div = 5000;
      endcase
      send_frame(d, stop, par, fb, fl);
      if (!stop) wait_ticks($urandom_range(0, 40));
      idle($urandom_range(1, 40));
      if ($urandom_range(0, 5) == 0) begin
        bus.rx_in = 1'b0;
        repeat ($urandom_range(1, 24)) @(negedge clk);
        idle(16);
      end
    end
    auto_ack = 1'b0;
    idle(32);
    cmp_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
